// File: rtl/reg_trace_unit.sv
// reg_trace_unit
//
// Watches a bank of 32-bit architectural register taps. It emits one compact
// change record {stamp, idx, value} per changed register over a valid/ready
// stream. A small show-ahead FIFO buffers the records. When a register changes
// again before its previous record was queued, only the latest value and
// stamp are kept, and the sticky coalesce_flag is raised.
//
// Ports:
//   clk           system clock, everything on the rising edge
//   reset         synchronous, active-high reset
//   regs          flattened taps, reg N (1-based) at [32N-1:32(N-1)]
//   trace_valid   a record is presented on trace_data
//   trace_ready   consumer takes the record when valid && ready at an edge
//   trace_data    {stamp[CYC_W-1:0], idx[3:0] (1-based), value[31:0]}; 0 when empty
//   fifo_level    current FIFO occupancy
//   coalesce_flag sticky: some intermediate register value was never traced

module reg_trace_unit #(
  parameter int NREGS = 10,
  parameter int CYC_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [32*NREGS-1:0]      regs,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [CYC_W+36-1:0]      trace_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     coalesce_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = CYC_W + 36;

  // Change-detection state
  logic [CYC_W-1:0] cyc_cnt;
  logic [31:0]      shadow [NREGS];
  logic [CYC_W-1:0] stamp  [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] chg;
  logic [NREGS-1:0] pop_onehot;
  logic             coal_hit;

  // FIFO state
  logic [RW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             fifo_full;
  logic             pop_fifo;
  logic             push_ok;
  logic             push_fifo;
  logic [RW-1:0]    push_rec;

  // A tap differs from its shadow copy: full 32-bit compare
  always_comb begin
    chg = '0;
    for (int i = 0; i < NREGS; i++) begin
      chg[i] = (regs[32*i +: 32] != shadow[i]);
    end
  end

  assign trace_valid = (count != '0);
  assign pop_fifo    = trace_valid && trace_ready;
  assign fifo_full   = (count == LW'(DEPTH));
  // A full FIFO still accepts a push when it is being drained this edge
  assign push_ok     = !fifo_full || pop_fifo;

  // Lowest pending register wins the single push slot. The record uses the
  // registered shadow and stamp, so a same-edge change on that register
  // is traced later, not merged into this record.
  always_comb begin
    pop_onehot = '0;
    push_fifo  = 1'b0;
    push_rec   = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (push_ok && pending[i] && !push_fifo) begin
        pop_onehot[i] = 1'b1;
        push_fifo     = 1'b1;
        push_rec      = {stamp[i], 4'(i + 1), shadow[i]};
      end
    end
  end

  // A change on a register that still has an un-queued record overwrites it
  assign coal_hit = |(chg & pending & ~pop_onehot);

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt       <= '0;
      pending       <= '0;
      coalesce_flag <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        shadow[i] <= '0;
        stamp[i]  <= '0;
      end
    end else begin
      cyc_cnt <= cyc_cnt + CYC_W'(1);
      pending <= (pending & ~pop_onehot) | chg;
      if (coal_hit) begin
        coalesce_flag <= 1'b1;
      end
      for (int i = 0; i < NREGS; i++) begin
        shadow[i] <= regs[32*i +: 32];
        if (chg[i]) begin
          stamp[i] <= cyc_cnt;
        end
      end
    end
  end

  // FIFO storage needs no reset; the output is gated by the occupancy count
  always_ff @(posedge clk) begin
    if (push_fifo) begin
      mem[wr_ptr] <= push_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fifo) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fifo) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_fifo, pop_fifo})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign trace_data = trace_valid ? mem[rd_ptr] : '0;
  assign fifo_level = count;

endmodule

// File: tb/tb_reg_trace_unit.sv
// tb_reg_trace_unit
//
// Randomised and directed stimulus for reg_trace_unit. A behavioural model
// tracks, per register, the last traced-from value, the stamp of the latest
// change and whether a record is still owed. It also keeps the FIFO as a
// queue of records. Each record the model enqueues is also pushed into a
// scoreboard queue. A separate monitor compares DUT output against the
// scoreboard and pops it on every handshake.

module tb_reg_trace_unit;

  localparam int NREGS = 10;
  localparam int CYC_W = 4;
  localparam int DEPTH = 8;
  localparam int RW    = CYC_W + 36;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [32*NREGS-1:0]  regs = '0;
  logic                 trace_ready = 1'b0;
  logic                 trace_valid;
  logic [RW-1:0]        trace_data;
  logic [LW-1:0]        fifo_level;
  logic                 coalesce_flag;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned          m_cnt = 0;
  logic [31:0]          m_shadow [NREGS];
  logic [CYC_W-1:0]     m_stamp  [NREGS];
  bit                   m_pend   [NREGS];
  bit                   m_coal = 1'b0;
  logic [RW-1:0]        m_fifo [$];
  logic [RW-1:0]        exp_q  [$];
  logic [32*NREGS-1:0]  regs_drv = '0;

  always #5 clk = ~clk;

  reg_trace_unit #(
    .NREGS(NREGS),
    .CYC_W(CYC_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .regs         (regs),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_data   (trace_data),
    .fifo_level   (fifo_level),
    .coalesce_flag(coalesce_flag)
  );

  task automatic compare(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // One clock edge of the model, applied with the inputs the DUT sampled
  task automatic model_step(input logic [32*NREGS-1:0] r, input logic rdy, input logic rst);
    int sel;
    logic [31:0] v;
    if (rst) begin
      m_cnt  = 0;
      m_coal = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        m_shadow[i] = '0;
        m_stamp[i]  = '0;
        m_pend[i]   = 1'b0;
      end
      m_fifo.delete();
      exp_q.delete();
      return;
    end
    if (m_fifo.size() > 0 && rdy) begin
      m_fifo.delete(0);
    end
    sel = -1;
    if (m_fifo.size() < DEPTH) begin
      for (int i = NREGS - 1; i >= 0; i--) begin
        if (m_pend[i]) sel = i;
      end
    end
    if (sel >= 0) begin
      m_fifo.push_back({m_stamp[sel], 4'(sel + 1), m_shadow[sel]});
      exp_q.push_back({m_stamp[sel], 4'(sel + 1), m_shadow[sel]});
      m_pend[sel] = 1'b0;
    end
    for (int i = 0; i < NREGS; i++) begin
      v = r[32*i +: 32];
      if (v != m_shadow[i]) begin
        if (m_pend[i]) m_coal = 1'b1;
        m_stamp[i]  = CYC_W'(m_cnt);
        m_shadow[i] = v;
        m_pend[i]   = 1'b1;
      end
    end
    m_cnt = (m_cnt + 1) % (1 << CYC_W);
  endtask

  task automatic apply_stimulus(input logic [32*NREGS-1:0] r, input logic rdy, input logic rst);
    @(negedge clk);
    regs        = r;
    trace_ready = rdy;
    reset       = rst;
    @(posedge clk);
    model_step(r, rdy, rst);
  endtask

  task automatic set_reg(input int n, input logic [31:0] v);
    regs_drv[32*(n-1) +: 32] = v;
  endtask

  task automatic check_output();
    logic [LW-1:0] want_lvl;
    want_lvl = LW'(m_fifo.size());
    compare("valid", 64'(trace_valid), 64'(m_fifo.size() > 0));
    compare("level", 64'(fifo_level), 64'(want_lvl));
    compare("coalesce", 64'(coalesce_flag), 64'(m_coal));
    if (trace_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        compare("record_present", 64'(1), 64'(0));
      end else begin
        compare("record", 64'(trace_data), 64'(exp_q[0]));
        if (trace_ready === 1'b1) exp_q.delete(0);
      end
    end else begin
      compare("idle_data", 64'(trace_data), 64'(0));
    end
  endtask

  // Monitor: samples between negedge and posedge, after inputs have settled
  initial begin
    for (int i = 0; i < NREGS; i++) begin
      m_shadow[i] = '0;
      m_stamp[i]  = '0;
      m_pend[i]   = 1'b0;
    end
    forever begin
      @(negedge clk);
      #3;
      check_output();
    end
  end

  initial begin
    // Quiet bus after reset
    regs_drv = '0;
    repeat (2) apply_stimulus(regs_drv, 1'b1, 1'b1);
    repeat (10) apply_stimulus(regs_drv, 1'b1, 1'b0);

    // Single change on reg3 at counter 2
    apply_stimulus(regs_drv, 1'b1, 1'b1);
    repeat (2) apply_stimulus(regs_drv, 1'b1, 1'b0);
    set_reg(3, 32'h5);
    repeat (6) apply_stimulus(regs_drv, 1'b1, 1'b0);

    // Three simultaneous changes at counter 4, emitted lowest index first
    regs_drv = '0;
    apply_stimulus(regs_drv, 1'b1, 1'b1);
    repeat (4) apply_stimulus(regs_drv, 1'b1, 1'b0);
    set_reg(1, 32'hA);
    set_reg(2, 32'hB);
    set_reg(10, 32'hC);
    repeat (8) apply_stimulus(regs_drv, 1'b1, 1'b0);

    // Backpressure fills the FIFO, then reg9 coalesces
    regs_drv = '0;
    apply_stimulus(regs_drv, 1'b1, 1'b1);
    for (int n = 1; n <= NREGS; n++) set_reg(n, 32'h100 + n);
    repeat (12) apply_stimulus(regs_drv, 1'b0, 1'b0);
    set_reg(9, 32'hBEEF);
    repeat (3) apply_stimulus(regs_drv, 1'b0, 1'b0);
    repeat (15) apply_stimulus(regs_drv, 1'b1, 1'b0);

    // Toggling register traced every cycle without coalescing
    regs_drv = '0;
    apply_stimulus(regs_drv, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      set_reg(4, (k % 2 == 0) ? 32'h1 : 32'h2);
      apply_stimulus(regs_drv, 1'b1, 1'b0);
    end
    repeat (4) apply_stimulus(regs_drv, 1'b1, 1'b0);

    // Reset while five records are queued, then a stamp that wraps
    regs_drv = '0;
    apply_stimulus(regs_drv, 1'b1, 1'b1);
    for (int n = 1; n <= 5; n++) set_reg(n, 32'h20 + n);
    repeat (6) apply_stimulus(regs_drv, 1'b0, 1'b0);
    regs_drv = '0;
    apply_stimulus(regs_drv, 1'b0, 1'b1);
    repeat (17) apply_stimulus(regs_drv, 1'b1, 1'b0);
    set_reg(7, 32'h77);
    repeat (4) apply_stimulus(regs_drv, 1'b1, 1'b0);

    // Random traffic with varying backpressure and rare resets
    regs_drv = '0;
    apply_stimulus(regs_drv, 1'b1, 1'b1);
    for (int c = 0; c < 800; c++) begin
      logic rdy;
      logic rst;
      for (int n = 1; n <= NREGS; n++) begin
        if ($urandom_range(0, 7) == 0) begin
          set_reg(n, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
        end
      end
      case ((c / 50) % 3)
        0:       rdy = ($urandom_range(0, 3) != 0);
        1:       rdy = ($urandom_range(0, 5) == 0);
        default: rdy = 1'b1;
      endcase
      rst = ($urandom_range(0, 299) == 0);
      apply_stimulus(regs_drv, rdy, rst);
    end

    // Drain everything still owed
    repeat (30) apply_stimulus(regs_drv, 1'b1, 1'b0);
    @(negedge clk);
    #4;
    compare("drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
